// File: rtl/fetch_top.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to the I-cache and
// hands instructions to decode through a registered slot backed by a one-entry skid buffer.
module fetch_top #(
  parameter int unsigned        PcWidth    = 32,
  parameter int unsigned        InstrWidth = 32,
  parameter logic [PcWidth-1:0] BootAddr   = 32'h0000_1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_fetch_i,
  input  logic                  branch_taken_i,
  input  logic [PcWidth-1:0]    branch_pc_i,
  output logic                  icache_req_valid_o,
  output logic [PcWidth-1:0]    icache_req_addr_o,
  input  logic                  icache_req_ready_i,
  input  logic                  icache_rsp_valid_i,
  input  logic [InstrWidth-1:0] icache_rsp_data_i,
  input  logic                  icache_rsp_error_i,
  output logic                  fetch_instr_valid_o,
  output logic [InstrWidth-1:0] fetch_instr_data_o,
  output logic [PcWidth-1:0]    fetch_instr_pc_o,
  output logic                  xcpt_fetch_misaligned_o,
  output logic                  xcpt_fetch_bus_error_o
);

  typedef enum logic [2:0] {StIssue, StWaitRsp, StHold, StDrain, StHalt} state_e;

  typedef struct packed {
    logic                  valid;
    logic                  misaligned;
    logic                  bus_error;
    logic [PcWidth-1:0]    pc;
    logic [InstrWidth-1:0] data;
  } entry_t;

  state_e             state_q, state_d;
  logic [PcWidth-1:0] pc_q, pc_d;
  entry_t             slot_q, slot_d;
  entry_t             skid_q, skid_d;
  entry_t             rsp_entry;
  logic               in_reset_q;
  logic               slot_free;
  logic               req_fire;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIssue;
      pc_q       <= BootAddr;
      slot_q     <= '0;
      skid_q     <= '0;
      in_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      slot_q     <= slot_d;
      skid_q     <= skid_d;
      in_reset_q <= 1'b0;
    end
  end

  assign slot_free = !slot_q.valid || !stall_fetch_i;
  assign req_fire  = icache_req_valid_o && icache_req_ready_i;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot_d  = slot_q;
    skid_d  = skid_q;

    rsp_entry            = '0;
    rsp_entry.valid      = 1'b1;
    rsp_entry.bus_error  = icache_rsp_error_i;
    rsp_entry.pc         = pc_q;
    rsp_entry.data       = icache_rsp_error_i ? '0 : icache_rsp_data_i;

    if (slot_q.valid && !stall_fetch_i) begin
      slot_d.valid = 1'b0;
    end

    if (branch_taken_i) begin
      pc_d   = branch_pc_i;
      slot_d = '0;
      skid_d = '0;
      unique case (state_q)
        StIssue:   state_d = req_fire ? StDrain : StIssue;
        // A response landing with the redirect is dropped, so nothing is left to drain.
        StWaitRsp: state_d = icache_rsp_valid_i ? StIssue : StDrain;
        StDrain:   state_d = icache_rsp_valid_i ? StIssue : StDrain;
        default:   state_d = StIssue;
      endcase
    end else begin
      unique case (state_q)
        StIssue: begin
          if (pc_q[1:0] != 2'b00) begin
            if (slot_free) begin
              slot_d            = '0;
              slot_d.valid      = 1'b1;
              slot_d.misaligned = 1'b1;
              slot_d.pc         = pc_q;
              state_d           = StHalt;
            end
          end else if (req_fire) begin
            state_d = StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (icache_rsp_valid_i) begin
            pc_d = pc_q + PcWidth'(4);
            if (slot_free) begin
              slot_d  = rsp_entry;
              state_d = icache_rsp_error_i ? StHalt : StIssue;
            end else begin
              skid_d  = rsp_entry;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (!stall_fetch_i) begin
            slot_d  = skid_q;
            skid_d  = '0;
            state_d = skid_q.bus_error ? StHalt : StIssue;
          end
        end
        StDrain: begin
          if (icache_rsp_valid_i) begin
            state_d = StIssue;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Request outputs depend on registered state only.
  always_comb begin
    icache_req_valid_o = (state_q == StIssue) && (pc_q[1:0] == 2'b00) && !in_reset_q;
    icache_req_addr_o  = pc_q;
  end

  assign fetch_instr_valid_o     = slot_q.valid;
  assign fetch_instr_data_o      = slot_q.data;
  assign fetch_instr_pc_o        = slot_q.pc;
  assign xcpt_fetch_misaligned_o = slot_q.misaligned;
  assign xcpt_fetch_bus_error_o  = slot_q.bus_error;

endmodule

// File: doc/fetch_top.md
# fetch_top

Instruction fetch stage, directly upstream of decode. Holds the architectural PC and issues one word request at a time to the instruction cache over a valid/ready handshake. Registers each returned instruction with its PC into a one-deep output slot backed by a one-entry skid buffer, so decode stalls never lose data. Handles redirects from the ALU and raises fetch exceptions: misaligned PC and bus error.

## Interface
- PC_WIDTH, 32, PC and address width
- INSTR_WIDTH, 32, instruction width
- BOOT_ADDR, 32'h0000_1000, PC after reset; must be word aligned
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall_fetch  in  1  decode cannot accept; the output slot holds
- branch_taken  in  1  one-cycle redirect pulse from ALU or exception handler
- branch_pc  in  PC_WIDTH  redirect target, sampled when branch_taken=1
- icache_req_valid  out  1  request valid
- icache_req_addr  out  PC_WIDTH  request word address
- icache_req_ready  in  1  cache accepts the request this cycle
- icache_rsp_valid  in  1  response valid, one cycle pulse, in order
- icache_rsp_data  in  INSTR_WIDTH  instruction word
- icache_rsp_error  in  1  bus error on this response
- fetch_instr_valid  out  1  output slot valid
- fetch_instr_data  out  INSTR_WIDTH  instruction; 0 when the slot carries an exception
- fetch_instr_pc  out  PC_WIDTH  PC of the slot
- xcpt_fetch_misaligned  out  1  slot carries a misaligned-PC exception
- xcpt_fetch_bus_error  out  1  slot carries a bus-error exception

## Operation
- State: pc_ff, FSM {ISSUE, WAIT_RSP, HOLD, DRAIN, HALT}, output slot, skid entry. The slot and the skid entry each hold {valid, data, pc, misaligned, bus_error}.
- Slot free when fetch_instr_valid=0 or stall_fetch=0. The slot is consumed on any cycle with valid=1 and stall_fetch=0.
- ISSUE:
  - If pc_ff[1:0]!=0: no request. Write an exception entry {misaligned=1, data=0, pc=pc_ff} to the slot when it is free, then go to HALT.
  - Otherwise icache_req_valid=1 and icache_req_addr=pc_ff. On icache_req_ready, go to WAIT_RSP.
- WAIT_RSP: on icache_rsp_valid, form the entry {data, pc=pc_ff, bus_error=icache_rsp_error}.
  - If the slot is free, write the entry to the slot; otherwise write it to the skid entry and go to HOLD.
  - pc_ff += 4, modulo 2^PC_WIDTH.
  - Next state: HALT if bus_error=1, else ISSUE when the entry went to the slot.
- HOLD: no request. When stall_fetch=0, skid moves to the slot and the skid entry clears. Next state is HALT if the moved entry has bus_error=1, else ISSUE.
- HALT: no requests. Exit only through a redirect.
- Redirect (branch_taken=1) has priority over every other event, including stall_fetch:
  - pc_ff <= branch_pc.
  - Slot and skid entry are cleared next cycle.
  - From ISSUE with a handshake completing the same cycle, or from WAIT_RSP without rsp_valid, go to DRAIN.
  - From WAIT_RSP with rsp_valid the same cycle, the response is discarded and the next state is ISSUE.
  - From ISSUE without a handshake, HOLD or HALT, go to ISSUE.
- DRAIN: no request. The next icache_rsp_valid is discarded, then go to ISSUE. A further redirect in DRAIN updates pc_ff and stays in DRAIN.
- At most one request is outstanding. icache_req_valid, once raised, stays high with a stable address until ready, unless a redirect occurs.

## Timing
- Reset values:
  - FSM=ISSUE, pc_ff=BOOT_ADDR.
  - fetch_instr_valid=0, fetch_instr_data=0, fetch_instr_pc=0, both xcpt outputs 0.
  - Skid entry invalid.
  - icache_req_valid=0 during the reset cycle.
- Reset asserted mid-operation aborts any outstanding request. A response arriving after reset is ignored.
- icache_req_valid and icache_req_addr are combinational from FSM/pc_ff only, with no input-to-output path. Every other output is registered.
- Request accepted at cycle N; response at cycle M>N; fetch_instr_valid=1 at M+1.
- Next request is issued at M+1. With a 1-cycle cache, throughput is one instruction per 2 cycles.
- Redirect at cycle R: fetch_instr_valid=0 at R+1. Request to branch_pc at R+1 when no response is pending.

## Test plan
- Reset release, cache ready=1 with 1-cycle latency, data=A+i -> requests to 0x1000, 0x1004, 0x1008. Decode sees (0x1000, A), (0x1004, A+1), … every 2 cycles, no exception flags.
- stall_fetch=1 for 6 cycles with a response arriving during the stall -> slot holds the first instruction and the skid holds the second with no request issued. After release, both appear in order with no loss or duplicate.
- branch_taken with branch_pc=0x2000 while WAIT_RSP and the response is 3 cycles late -> DRAIN discards that response. Next request addr=0x2000, no instruction from the old path reaches decode.
- Redirect to 0x2002 -> no cache request; slot carries misaligned=1, pc=0x2002, data=0. Then HALT until a redirect to 0x3000 resumes fetch at 0x3000.
- Response with icache_rsp_error=1 at pc 0x1004 -> slot carries bus_error=1, pc=0x1004, and fetch halts with no further requests. A redirect clears the halt.
- Reset asserted while WAIT_RSP and a stale response arriving 1 cycle later -> outputs at reset values, stale response ignored, first request at 0x1000.
